// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive path.
// Provides the captured Ethernet/IPv4/UDP header type, wire-byte offsets of
// the fields the UDP parser filters on, protocol constants, the CRC-32
// constants, the parser FSM state type and small helpers that pull
// network-order fields out of a captured header.
package rgmii_pkg;

  localparam int HEADER_BYTES = 42;

  localparam logic [7:0]  PREAMBULE_VAL   = 8'h55;
  localparam logic [7:0]  SFD_VAL         = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
  localparam logic [7:0]  IPV4_VER_IHL    = 8'h45;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

  // Wire-byte offsets inside the 42-byte Ethernet + IPv4 + UDP header.
  localparam int OFF_MAC_DST   = 0;
  localparam int OFF_ETH_TYPE  = 12;
  localparam int OFF_VER_IHL   = 14;
  localparam int OFF_IP_PROTO  = 23;
  localparam int OFF_IP_DST    = 30;
  localparam int OFF_UDP_DPORT = 36;
  localparam int OFF_UDP_LEN   = 38;

  // Wire byte k lives at bits [8k+7:8k].
  typedef logic [8*HEADER_BYTES-1:0] ethernet_header_t;

  typedef enum logic [2:0] {
    WAIT_GAP,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    TRAILER,
    DROP
  } rx_state_t;

  function automatic logic [7:0] hdr_byte(input ethernet_header_t h, input int k);
    return h[8*k +: 8];
  endfunction

  // Multi-byte fields are network order: the first wire byte is the MSB.
  function automatic logic [15:0] hdr_be16(input ethernet_header_t h, input int k);
    return {hdr_byte(h, k), hdr_byte(h, k + 1)};
  endfunction

  function automatic logic [31:0] hdr_be32(input ethernet_header_t h, input int k);
    return {hdr_be16(h, k), hdr_be16(h, k + 2)};
  endfunction

  function automatic logic [47:0] hdr_be48(input ethernet_header_t h, input int k);
    return {hdr_be16(h, k), hdr_be32(h, k + 2)};
  endfunction

endpackage

// File: rtl/crc32_eth.sv
// Byte-wise Ethernet CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF).
// Ports:
//   clk_i, arstn_i : clock, asynchronous active-low reset (register -> init)
//   en_i           : fold data_i into the running CRC this cycle
//   clear_i        : reload the init value (wins over en_i)
//   data_i         : byte, LSB is the first bit on the wire
//   crc_o          : running register, bit-reversed so that a good frame
//                    (data + FCS) leaves the residue 0xC704DD7B
module crc32_eth
  import rgmii_pkg::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC32_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (en_i) begin
      crc_d = crc32_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  // The reflected register's magic residue 0xDEBB20E3 reads 0xC704DD7B
  // once bit-reversed.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      crc_o[i] = crc_q[31-i];
    end
  end

endmodule

// File: rtl/udp_rx_parser.sv
// Receive-side Ethernet/IPv4/UDP parser on a de-DDR'd RGMII byte stream.
// Strips preamble/SFD, captures the 42-byte header, filters on protocol and
// (optionally) local MAC/IP/port, streams the UDP payload one cycle after it
// arrives and reports a per-frame status pulse with CRC and drop flags.
// Ports:
//   clk_i, arstn_i            : byte clock, asynchronous active-low reset
//   rx_dv_i, rx_er_i          : byte valid, PHY error for the current byte
//   rx_data_i                 : received byte, preamble included
//   check_destination_i       : enable MAC/IP/port filtering
//   fpga_mac_i/ip_i/port_i    : local addresses, network order
//   m_axis_tdata/tvalid/tlast : UDP payload stream, no back-pressure
//   hdr_o                     : last captured header
//   frame_done_o              : one-cycle end-of-frame pulse
//   crc_err_o, drop_o         : frame status, valid with frame_done_o
module udp_rx_parser
  import rgmii_pkg::*;
#(
  parameter bit CHECK_BROADCAST = 1'b1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             rx_dv_i,
  input  logic             rx_er_i,
  input  logic [7:0]       rx_data_i,
  input  logic             check_destination_i,
  input  logic [47:0]      fpga_mac_i,
  input  logic [31:0]      fpga_ip_i,
  input  logic [15:0]      fpga_port_i,
  output logic [7:0]       m_axis_tdata_o,
  output logic             m_axis_tvalid_o,
  output logic             m_axis_tlast_o,
  output ethernet_header_t hdr_o,
  output logic             frame_done_o,
  output logic             crc_err_o,
  output logic             drop_o
);

  rx_state_t        state_q, state_d;
  logic [2:0]       pre_cnt_q, pre_cnt_d;
  logic [5:0]       hdr_cnt_q, hdr_cnt_d;
  logic [15:0]      pay_cnt_q, pay_cnt_d;
  ethernet_header_t hdr_q, hdr_d;
  logic             er_seen_q, er_seen_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             done_q, done_d;
  logic             crc_err_q, crc_err_d;
  logic             drop_q, drop_d;

  logic             crc_en, crc_clear;
  logic [31:0]      crc_val;

  crc32_eth u_crc (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .en_i    (crc_en),
    .clear_i (crc_clear),
    .data_i  (rx_data_i),
    .crc_o   (crc_val)
  );

  // Filters are evaluated while the 42nd byte (UDP checksum) is on the bus,
  // so every field they need is already held in hdr_q.
  logic [15:0] udp_len;
  logic        base_ok, mac_ok, dest_ok, filt_pass, frame_bad;

  assign udp_len = hdr_be16(hdr_q, OFF_UDP_LEN);

  assign base_ok = (hdr_be16(hdr_q, OFF_ETH_TYPE) == ETH_TYPE_IPV4) &&
                   (hdr_byte(hdr_q, OFF_VER_IHL) == IPV4_VER_IHL) &&
                   (hdr_byte(hdr_q, OFF_IP_PROTO) == IP_PROTO_UDP) &&
                   (udp_len >= 16'd8);

  assign mac_ok = (hdr_be48(hdr_q, OFF_MAC_DST) == fpga_mac_i) ||
                  (CHECK_BROADCAST && (hdr_be48(hdr_q, OFF_MAC_DST) == 48'hFFFF_FFFF_FFFF));

  assign dest_ok = !check_destination_i ||
                   (mac_ok &&
                    (hdr_be32(hdr_q, OFF_IP_DST) == fpga_ip_i) &&
                    (hdr_be16(hdr_q, OFF_UDP_DPORT) == fpga_port_i));

  assign filt_pass = base_ok && dest_ok;

  // The CRC register already holds the FCS-inclusive value when the
  // falling edge of rx_dv_i is sampled.
  assign frame_bad = (crc_val != CRC32_RESIDUE) || er_seen_q;

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    hdr_d     = hdr_q;
    er_seen_d = er_seen_q;
    tdata_d   = 8'h00;
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    done_d    = 1'b0;
    crc_err_d = 1'b0;
    drop_d    = 1'b0;
    crc_en    = 1'b0;
    crc_clear = 1'b0;

    unique case (state_q)
      WAIT_GAP: begin
        if (!rx_dv_i) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 3'd0;
        end
      end

      PREAMBLE: begin
        if (!rx_dv_i) begin
          pre_cnt_d = 3'd0;
        end else if (rx_data_i == PREAMBULE_VAL) begin
          // An eighth 0x55 is not a valid preamble.
          if (pre_cnt_q == 3'd7) begin
            state_d   = WAIT_GAP;
            pre_cnt_d = 3'd0;
          end else begin
            pre_cnt_d = pre_cnt_q + 3'd1;
          end
        end else if ((rx_data_i == SFD_VAL) && (pre_cnt_q != 3'd0)) begin
          state_d   = HEADER;
          pre_cnt_d = 3'd0;
          hdr_cnt_d = 6'd0;
          er_seen_d = 1'b0;
          crc_clear = 1'b1;
        end else begin
          state_d   = WAIT_GAP;
          pre_cnt_d = 3'd0;
        end
      end

      HEADER: begin
        if (rx_dv_i) begin
          crc_en    = 1'b1;
          er_seen_d = er_seen_q | rx_er_i;
          hdr_d[8*hdr_cnt_q +: 8] = rx_data_i;
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (hdr_cnt_q == 6'(HEADER_BYTES - 1)) begin
            hdr_cnt_d = 6'd0;
            if (!filt_pass) begin
              state_d = DROP;
            end else if (udp_len > 16'd8) begin
              state_d   = PAYLOAD;
              pay_cnt_d = udp_len - 16'd8;
            end else begin
              state_d = TRAILER;
            end
          end
        end else begin
          state_d   = PREAMBLE;
          hdr_cnt_d = 6'd0;
          done_d    = 1'b1;
          crc_err_d = frame_bad;
          drop_d    = 1'b1;
        end
      end

      PAYLOAD: begin
        if (rx_dv_i) begin
          crc_en    = 1'b1;
          er_seen_d = er_seen_q | rx_er_i;
          tvalid_d  = 1'b1;
          tdata_d   = rx_data_i;
          pay_cnt_d = pay_cnt_q - 16'd1;
          if (pay_cnt_q == 16'd1) begin
            tlast_d = 1'b1;
            state_d = TRAILER;
          end
        end else begin
          // Truncated payload: close the stream with a dummy last beat.
          state_d   = PREAMBLE;
          pay_cnt_d = 16'd0;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b1;
          done_d    = 1'b1;
          crc_err_d = frame_bad;
          drop_d    = 1'b1;
        end
      end

      TRAILER, DROP: begin
        if (rx_dv_i) begin
          crc_en    = 1'b1;
          er_seen_d = er_seen_q | rx_er_i;
        end else begin
          state_d   = PREAMBLE;
          done_d    = 1'b1;
          crc_err_d = frame_bad;
          drop_d    = (state_q == DROP);
        end
      end

      default: begin
        state_d = WAIT_GAP;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= WAIT_GAP;
      pre_cnt_q <= 3'd0;
      hdr_cnt_q <= 6'd0;
      pay_cnt_q <= 16'd0;
      hdr_q     <= '0;
      er_seen_q <= 1'b0;
      tdata_q   <= 8'h00;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      hdr_q     <= hdr_d;
      er_seen_q <= er_seen_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      done_q    <= done_d;
      crc_err_q <= crc_err_d;
      drop_q    <= drop_d;
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign hdr_o           = hdr_q;
  assign frame_done_o    = done_q;
  assign crc_err_o       = crc_err_q;
  assign drop_o          = drop_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: directed frames plus randomized
// frames compared against a byte-level reference model.
module tb_udp_rx_parser;
  import rgmii_pkg::*;

  localparam logic [47:0] MY_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] MY_IP   = 32'hC0A8_0164;
  localparam logic [15:0] MY_PORT = 16'd5000;

  logic             clk_i = 1'b0;
  logic             arstn_i;
  logic             rx_dv_i, rx_er_i;
  logic [7:0]       rx_data_i;
  logic             check_destination_i;
  logic [47:0]      fpga_mac_i;
  logic [31:0]      fpga_ip_i;
  logic [15:0]      fpga_port_i;
  logic [7:0]       m_axis_tdata_o;
  logic             m_axis_tvalid_o, m_axis_tlast_o;
  ethernet_header_t hdr_o;
  logic             frame_done_o, crc_err_o, drop_o;

  always #4 clk_i = ~clk_i;

  udp_rx_parser #(.CHECK_BROADCAST(1'b1)) dut (
    .clk_i               (clk_i),
    .arstn_i             (arstn_i),
    .rx_dv_i             (rx_dv_i),
    .rx_er_i             (rx_er_i),
    .rx_data_i           (rx_data_i),
    .check_destination_i (check_destination_i),
    .fpga_mac_i          (fpga_mac_i),
    .fpga_ip_i           (fpga_ip_i),
    .fpga_port_i         (fpga_port_i),
    .m_axis_tdata_o      (m_axis_tdata_o),
    .m_axis_tvalid_o     (m_axis_tvalid_o),
    .m_axis_tlast_o      (m_axis_tlast_o),
    .hdr_o               (hdr_o),
    .frame_done_o        (frame_done_o),
    .crc_err_o           (crc_err_o),
    .drop_o              (drop_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] frm[$];
  logic [7:0] got_d[$];
  bit         got_l[$];
  int         done_cnt;
  bit         got_crc, got_drop;
  logic [7:0] exp_d[$];
  bit         exp_l[$];
  int         exp_done;
  bit         exp_crc, exp_drop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Sample outputs on the falling edge, then drive the next input byte.
  task automatic drive(input bit dv, input bit er, input logic [7:0] d);
    @(negedge clk_i);
    if (arstn_i) begin
      if (m_axis_tvalid_o) begin
        got_d.push_back(m_axis_tdata_o);
        got_l.push_back(m_axis_tlast_o);
      end
      if (frame_done_o) begin
        done_cnt++;
        got_crc  = crc_err_o;
        got_drop = drop_o;
      end
    end
    rx_dv_i   = dv;
    rx_er_i   = er;
    rx_data_i = d;
  endtask

  task automatic build_frame(input logic [47:0] dmac, input logic [31:0] dip,
                             input logic [15:0] dport, input logic [15:0] etype,
                             input logic [7:0] verihl, input logic [7:0] proto,
                             input logic [15:0] udplen, input int plen, input bit flip);
    logic [31:0] c;
    logic [15:0] iplen;
    frm.delete();
    iplen = 16'(28 + plen);
    for (int i = 5; i >= 0; i--) frm.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(8'(i + 1));
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(verihl); frm.push_back(8'h00);
    frm.push_back(iplen[15:8]); frm.push_back(iplen[7:0]);
    frm.push_back(8'h12); frm.push_back(8'h34); frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(proto);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h01); frm.push_back(8'h0A);
    for (int i = 3; i >= 0; i--) frm.push_back(dip[8*i +: 8]);
    frm.push_back(8'h30); frm.push_back(8'h39);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(udplen[15:8]); frm.push_back(udplen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom_range(0, 255)));
    while (frm.size() < 60) frm.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    if (flip) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h10;
  endtask

  // Expected behaviour derived from the frame bytes actually put on the wire.
  task automatic model(input int npre, input int n, input bit er, input bit chk);
    logic [31:0] r;
    logic [47:0] mac;
    logic [31:0] ip;
    int          len, plen, port;
    bit          pass;
    exp_d.delete(); exp_l.delete();
    exp_done = 0; exp_crc = 0; exp_drop = 0;
    if (npre < 1 || npre > 7) return;
    exp_done = 1;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) r = crc_upd(r, frm[i]);
    exp_crc = er || (r != 32'hDEBB20E3);
    if (n < 42) begin exp_drop = 1; return; end
    mac = '0; ip = '0;
    for (int k = 0; k < 6; k++) mac = {mac[39:0], frm[k]};
    for (int k = 30; k < 34; k++) ip = {ip[23:0], frm[k]};
    port = {frm[36], frm[37]};
    len  = {frm[38], frm[39]};
    pass = ({frm[12], frm[13]} == 16'h0800) && (frm[14] == 8'h45) &&
           (frm[23] == 8'h11) && (len >= 8);
    if (chk) pass = pass && (mac == MY_MAC || mac == 48'hFFFF_FFFF_FFFF) &&
                    (ip == MY_IP) && (port == int'(MY_PORT));
    if (!pass) begin exp_drop = 1; return; end
    plen = len - 8;
    if (n - 42 >= plen) begin
      for (int i = 0; i < plen; i++) begin
        exp_d.push_back(frm[42+i]); exp_l.push_back(i == plen - 1);
      end
    end else begin
      for (int i = 42; i < n; i++) begin exp_d.push_back(frm[i]); exp_l.push_back(1'b0); end
      exp_d.push_back(8'h00); exp_l.push_back(1'b1);
      exp_drop = 1;
    end
  endtask

  task automatic send_frame(input int npre, input int n, input int er_idx, input int rst_idx);
    got_d.delete(); got_l.delete();
    done_cnt = 0; got_crc = 0; got_drop = 0;
    repeat (12) drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, PREAMBULE_VAL);
    drive(1'b1, 1'b0, SFD_VAL);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == er_idx, frm[i]);
      if (i == rst_idx) begin
        #1 arstn_i = 1'b0;
        #1;
        check_eq("rst_mid_tvalid", m_axis_tvalid_o, 0);
        check_eq("rst_mid_done", frame_done_o, 0);
        check_eq("rst_mid_hdr", |hdr_o, 0);
        #1 arstn_i = 1'b1;
        got_d.delete(); got_l.delete(); done_cnt = 0;
      end
    end
    repeat (6) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic compare(input string tag);
    int m;
    check_eq({tag, "_nbeats"}, got_d.size(), exp_d.size());
    m = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < m; i++) begin
      check_eq({tag, "_tdata"}, got_d[i], exp_d[i]);
      check_eq({tag, "_tlast"}, got_l[i], exp_l[i]);
    end
    check_eq({tag, "_done_cycles"}, done_cnt, exp_done);
    if (exp_done != 0) begin
      check_eq({tag, "_crc_err"}, got_crc, exp_crc);
      check_eq({tag, "_drop"}, got_drop, exp_drop);
    end
  endtask

  task automatic run(input string tag, input int npre, input int n, input int er_idx, input bit chk);
    check_destination_i = chk;
    send_frame(npre, n, er_idx, -1);
    model(npre, n, (er_idx >= 0) && (er_idx < n), chk);
    compare(tag);
  endtask

  initial begin
    arstn_i = 1'b0;
    rx_dv_i = 1'b0; rx_er_i = 1'b0; rx_data_i = 8'h00;
    check_destination_i = 1'b1;
    fpga_mac_i = MY_MAC; fpga_ip_i = MY_IP; fpga_port_i = MY_PORT;
    repeat (3) @(negedge clk_i);
    check_eq("rst_tvalid", m_axis_tvalid_o, 0);
    check_eq("rst_tlast", m_axis_tlast_o, 0);
    check_eq("rst_tdata", m_axis_tdata_o, 0);
    check_eq("rst_done", frame_done_o, 0);
    check_eq("rst_crc_err", crc_err_o, 0);
    check_eq("rst_drop", drop_o, 0);
    check_eq("rst_hdr", |hdr_o, 0);
    arstn_i = 1'b1;

    // Good frame, 10-byte payload.
    build_frame(MY_MAC, MY_IP, MY_PORT, 16'h0800, 8'h45, 8'h11, 16'd18, 10, 1'b0);
    run("good", 7, frm.size(), -1, 1'b1);
    check_eq("good_nbeats_const", got_d.size(), 10);
    check_eq("good_crc_const", got_crc, 0);
    for (int k = 0; k < 42; k++) check_eq("good_hdr_byte", hdr_o[8*k +: 8], frm[k]);

    // Corrupted FCS.
    build_frame(MY_MAC, MY_IP, MY_PORT, 16'h0800, 8'h45, 8'h11, 16'd18, 10, 1'b1);
    run("fcs", 7, frm.size(), -1, 1'b1);
    check_eq("fcs_crc_const", got_crc, 1);

    // Wrong port, filtered then unfiltered.
    build_frame(MY_MAC, MY_IP, 16'd5001, 16'h0800, 8'h45, 8'h11, 16'd18, 10, 1'b0);
    run("port_chk", 7, frm.size(), -1, 1'b1);
    check_eq("port_chk_drop_const", got_drop, 1);
    run("port_nochk", 7, frm.size(), -1, 1'b0);
    check_eq("port_nochk_nbeats_const", got_d.size(), 10);

    // Empty UDP datagram padded to minimum size.
    build_frame(MY_MAC, MY_IP, MY_PORT, 16'h0800, 8'h45, 8'h11, 16'd8, 0, 1'b0);
    run("len8", 7, frm.size(), -1, 1'b1);
    check_eq("len8_frame_len", frm.size(), 64);

    // Truncated after 4 payload bytes.
    build_frame(MY_MAC, MY_IP, MY_PORT, 16'h0800, 8'h45, 8'h11, 16'd18, 10, 1'b0);
    run("trunc", 7, 46, -1, 1'b1);
    check_eq("trunc_nbeats_const", got_d.size(), 5);

    // Reset mid-payload with rx_dv still high, then a normal frame.
    check_destination_i = 1'b1;
    send_frame(7, frm.size(), -1, 47);
    check_eq("rst_frame_nbeats", got_d.size(), 0);
    check_eq("rst_frame_done", done_cnt, 0);
    run("after_rst", 7, frm.size(), -1, 1'b1);

    // Randomized frames.
    for (int t = 0; t < 40; t++) begin
      logic [47:0] dmac;
      logic [31:0] dip;
      logic [15:0] dport, etype, ulen;
      logic [7:0]  vi, pr;
      int          plen, npre, n, er_idx, sel;
      bit          flip, chk;
      plen = $urandom_range(0, 30);
      ulen = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 60)) : 16'(plen + 8);
      sel  = $urandom_range(0, 9);
      dmac = (sel < 6) ? MY_MAC : (sel < 8) ? 48'hFFFF_FFFF_FFFF : {16'h0A0B, 32'($urandom)};
      dip   = ($urandom_range(0, 5) == 0) ? (MY_IP ^ 32'h1) : MY_IP;
      dport = ($urandom_range(0, 5) == 0) ? (MY_PORT + 16'd1) : MY_PORT;
      etype = ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800;
      vi    = ($urandom_range(0, 9) == 0) ? 8'h46 : 8'h45;
      pr    = ($urandom_range(0, 9) == 0) ? 8'h06 : 8'h11;
      flip  = ($urandom_range(0, 4) == 0);
      build_frame(dmac, dip, dport, etype, vi, pr, ulen, plen, flip);
      npre   = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 8)
                                           : $urandom_range(1, 7);
      n      = ($urandom_range(0, 4) == 0) ? $urandom_range(1, frm.size()) : frm.size();
      er_idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      chk    = $urandom_range(0, 1) == 1;
      run("rand", npre, n, er_idx, chk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
